// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the
// stage-register control word, and the priority decode used on every
// non-frozen cycle.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_IDX_W_DEF     = 5;
  localparam int STALL_TIMEOUT_DEF = 1023;
  localparam int CNT_W_DEF         = 32;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hazard_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic imem_hold;
    logic imem_use_held;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_FREEZE = '0;

  // Redirect beats load-use: the younger load-use consumer is squashed anyway.
  function automatic stage_ctl_t run_ctl(input logic redirect, input logic load_use);
    stage_ctl_t c;
    c = CTL_FREEZE;
    c.idex_en  = 1'b1;
    c.exmem_en = 1'b1;
    c.memwb_en = 1'b1;
    if (redirect) begin
      c.pc_en      = 1'b1;
      c.ifid_en    = 1'b1;
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      c.idex_flush = 1'b1;
    end else begin
      c.pc_en   = 1'b1;
      c.ifid_en = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. master = datapath side,
// slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 32
);
  logic                 imem_req, imem_resp, dmem_req, dmem_resp;
  logic                 idex_mem_read;
  logic [REG_IDX_W-1:0] idex_rd, ifid_rs1, ifid_rs2;
  logic                 ifid_use_rs1, ifid_use_rs2, ex_redirect;
  logic                 pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic                 ifid_flush, idex_flush, imem_hold, imem_use_held;
  logic                 hang_err;
  logic [CNT_W-1:0]     stall_cycles, loaduse_cnt, flush_cnt;

  modport master (
    output imem_req, imem_resp, dmem_req, dmem_resp, idex_mem_read, idex_rd,
           ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, ex_redirect,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           imem_hold, imem_use_held, hang_err, stall_cycles, loaduse_cnt, flush_cnt
  );

  modport slave (
    input  imem_req, imem_resp, dmem_req, dmem_resp, idex_mem_read, idex_rd,
           ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, ex_redirect,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           imem_hold, imem_use_held, hang_err, stall_cycles, loaduse_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_perf_ctrs.sv
// Free-running wrap-around perf counters for freeze cycles, load-use
// bubbles and redirect flushes.
module hazard_perf_ctrs #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             loaduse_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [CNT_W-1:0] stall_q, stall_d, lu_q, lu_d, fl_q, fl_d;

  // Next-count: each counter bumps by one on its event, wrapping naturally.
  always_comb begin
    stall_d = stall_q + CNT_W'(stall_inc);
    lu_d    = lu_q + CNT_W'(loaduse_inc);
    fl_d    = fl_q + CNT_W'(flush_inc);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      lu_q    <= '0;
      fl_q    <= '0;
    end else begin
      stall_q <= stall_d;
      lu_q    <= lu_d;
      fl_q    <= fl_d;
    end
  end

  assign stall_cycles = stall_q;
  assign loaduse_cnt  = lu_q;
  assign flush_cnt    = fl_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB registers.
// Freezes the whole pipe while imem or dmem is outstanding, remembers a
// response that lands early (split imem/dmem), then releases with normal
// redirect/load-use priority. Outputs are combinational (zero latency).
// Optional: HAZARD_PERF_CNT_EN adds the perf counters; otherwise the
// counter outputs read zero.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int              WAIT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TMO  = WAIT_W'(STALL_TIMEOUT);

  hazard_state_e     state_q, state_d;
  logic              imem_got_q, imem_got_d, dmem_got_q, dmem_got_d;
  logic              hang_q, hang_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              imem_pend, dmem_pend, mem_busy, load_use;
  stage_ctl_t        ctl;

  assign imem_pend = bus.imem_req & ~bus.imem_resp & ~imem_got_q;
  assign dmem_pend = bus.dmem_req & ~bus.dmem_resp & ~dmem_got_q;
  assign mem_busy  = imem_pend | dmem_pend;
  // x0 is hardwired zero, so a load to it never creates a dependency.
  assign load_use  = bus.idex_mem_read && (bus.idex_rd != '0) &&
                     ((bus.ifid_use_rs1 && (bus.ifid_rs1 == bus.idex_rd)) ||
                      (bus.ifid_use_rs2 && (bus.ifid_rs2 == bus.idex_rd)));

  // Next state, response bookkeeping, timeout and stage controls.
  always_comb begin
    state_d    = state_q;
    imem_got_d = imem_got_q;
    dmem_got_d = dmem_got_q;
    wait_cnt_d = wait_cnt_q;
    hang_d     = hang_q;
    ctl        = CTL_FREEZE;
    if (mem_busy) begin
      state_d = MEM_WAIT;
      // Fetch data arrived but dmem still outstanding: park it until release.
      if (bus.imem_resp && dmem_pend) begin
        ctl.imem_hold = 1'b1;
        imem_got_d    = 1'b1;
      end
      if (bus.dmem_resp && imem_pend) dmem_got_d = 1'b1;
      if (state_q == MEM_WAIT) begin
        if (wait_cnt_q != TMO) wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_d == TMO) hang_d = 1'b1;
      end
    end else begin
      // Release (or plain RUN): EX is still holding any redirect seen in the freeze.
      ctl               = run_ctl(bus.ex_redirect, load_use);
      ctl.imem_use_held = imem_got_q;
      state_d           = RUN;
      imem_got_d        = 1'b0;
      dmem_got_d        = 1'b0;
      wait_cnt_d        = '0;
    end
    if (!rst) ctl = CTL_FREEZE;
  end

  // State and sticky-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      imem_got_q <= 1'b0;
      dmem_got_q <= 1'b0;
      wait_cnt_q <= '0;
      hang_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_got_q <= imem_got_d;
      dmem_got_q <= dmem_got_d;
      wait_cnt_q <= wait_cnt_d;
      hang_q     <= hang_d;
    end
  end

  assign bus.pc_en         = ctl.pc_en;
  assign bus.ifid_en       = ctl.ifid_en;
  assign bus.idex_en       = ctl.idex_en;
  assign bus.exmem_en      = ctl.exmem_en;
  assign bus.memwb_en      = ctl.memwb_en;
  assign bus.ifid_flush    = ctl.ifid_flush;
  assign bus.idex_flush    = ctl.idex_flush;
  assign bus.imem_hold     = ctl.imem_hold;
  assign bus.imem_use_held = ctl.imem_use_held;
  assign bus.hang_err      = hang_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, loaduse_inc, flush_inc;
  assign stall_inc   = mem_busy;
  assign loaduse_inc = ~mem_busy & ~bus.ex_redirect & load_use;
  assign flush_inc   = ~mem_busy & bus.ex_redirect;

  hazard_perf_ctrs #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_inc    (stall_inc),
    .loaduse_inc  (loaduse_inc),
    .flush_inc    (flush_inc),
    .stall_cycles (bus.stall_cycles),
    .loaduse_cnt  (bus.loaduse_cnt),
    .flush_cnt    (bus.flush_cnt)
  );
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.loaduse_cnt  = {CNT_W{1'b0}};
  assign bus.flush_cnt    = {CNT_W{1'b0}};
`endif
endmodule
